// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU decode/issue stage:
// RV32I opcode/funct encodings, ALU operator codes and the issue entry record.
package alu_issue_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_OPERATOR_ADD  = 4'd0;
    localparam logic [3:0] ALU_OPERATOR_SUB  = 4'd1;
    localparam logic [3:0] ALU_OPERATOR_SLL  = 4'd2;
    localparam logic [3:0] ALU_OPERATOR_SLT  = 4'd3;
    localparam logic [3:0] ALU_OPERATOR_SLTU = 4'd4;
    localparam logic [3:0] ALU_OPERATOR_XOR  = 4'd5;
    localparam logic [3:0] ALU_OPERATOR_SRL  = 4'd6;
    localparam logic [3:0] ALU_OPERATOR_SRA  = 4'd7;
    localparam logic [3:0] ALU_OPERATOR_OR   = 4'd8;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] operand1;
        logic [31:0] operand2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } issue_t;

    localparam issue_t ISSUE_RESET = '{
        op:       ALU_OPERATOR_ADD,
        operand1: 32'd0,
        operand2: 32'd0,
        rd:       5'd0,
        rd_we:    1'b0,
        illegal:  1'b0
    };

    // Sign-extend the 12-bit I-type immediate.
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Pure combinational decode of one RV32I instruction into ALU operator,
// operands, destination and illegal flag. Sources arrive already bypassed.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output issue_t      fields
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_u_s;
    logic [31:0] shamt_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign rd_s     = instr[11:7];
    assign imm_i_s  = sext12(instr[31:20]);
    assign imm_u_s  = {instr[31:12], 12'd0};
    assign shamt_s  = {27'd0, instr[24:20]};

    logic        legal_s;
    logic [3:0]  op_s;
    logic [31:0] opnd1_s;
    logic [31:0] opnd2_s;

    // Select operator and operands by opcode/funct; anything unknown is left illegal.
    always_comb begin
        legal_s = 1'b0;
        op_s    = ALU_OPERATOR_ADD;
        opnd1_s = 32'd0;
        opnd2_s = 32'd0;
        case (opcode_s)
            OPCODE_OP: begin
                opnd1_s = src1;
                opnd2_s = src2;
                case (funct3_s)
                    FUNCT3_ADD: begin
                        if (funct7_s == FUNCT7_BASE) begin
                            legal_s = 1'b1;
                            op_s    = ALU_OPERATOR_ADD;
                        end else if (funct7_s == FUNCT7_ALT) begin
                            legal_s = 1'b1;
                            op_s    = ALU_OPERATOR_SUB;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    FUNCT3_SLL:  begin legal_s = (funct7_s == FUNCT7_BASE); op_s = ALU_OPERATOR_SLL;  end
                    FUNCT3_SLT:  begin legal_s = (funct7_s == FUNCT7_BASE); op_s = ALU_OPERATOR_SLT;  end
                    FUNCT3_SLTU: begin legal_s = (funct7_s == FUNCT7_BASE); op_s = ALU_OPERATOR_SLTU; end
                    FUNCT3_XOR:  begin legal_s = (funct7_s == FUNCT7_BASE); op_s = ALU_OPERATOR_XOR;  end
                    FUNCT3_SR: begin
                        if (funct7_s == FUNCT7_BASE) begin
                            legal_s = 1'b1;
                            op_s    = ALU_OPERATOR_SRL;
                        end else if (funct7_s == FUNCT7_ALT) begin
                            legal_s = 1'b1;
                            op_s    = ALU_OPERATOR_SRA;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    FUNCT3_OR:   begin legal_s = (funct7_s == FUNCT7_BASE); op_s = ALU_OPERATOR_OR;   end
                    // AND: the ALU has no AND operator
                    default:     legal_s = 1'b0;
                endcase
            end
            OPCODE_OP_IMM: begin
                opnd1_s = src1;
                opnd2_s = imm_i_s;
                case (funct3_s)
                    FUNCT3_ADD:  begin legal_s = 1'b1; op_s = ALU_OPERATOR_ADD;  end
                    FUNCT3_SLT:  begin legal_s = 1'b1; op_s = ALU_OPERATOR_SLT;  end
                    FUNCT3_SLTU: begin legal_s = 1'b1; op_s = ALU_OPERATOR_SLTU; end
                    FUNCT3_XOR:  begin legal_s = 1'b1; op_s = ALU_OPERATOR_XOR;  end
                    FUNCT3_OR:   begin legal_s = 1'b1; op_s = ALU_OPERATOR_OR;   end
                    FUNCT3_SLL: begin
                        opnd2_s = shamt_s;
                        legal_s = (funct7_s == FUNCT7_BASE);
                        op_s    = ALU_OPERATOR_SLL;
                    end
                    FUNCT3_SR: begin
                        opnd2_s = shamt_s;
                        if (funct7_s == FUNCT7_BASE) begin
                            legal_s = 1'b1;
                            op_s    = ALU_OPERATOR_SRL;
                        end else if (funct7_s == FUNCT7_ALT) begin
                            legal_s = 1'b1;
                            op_s    = ALU_OPERATOR_SRA;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    // ANDI: no AND operator
                    default: legal_s = 1'b0;
                endcase
            end
            OPCODE_LUI: begin
                legal_s = 1'b1;
                opnd1_s = 32'd0;
                opnd2_s = imm_u_s;
            end
            OPCODE_AUIPC: begin
                legal_s = 1'b1;
                opnd1_s = pc;
                opnd2_s = imm_u_s;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal instructions become a harmless ADD 0,0 with no register write.
    always_comb begin
        fields    = ISSUE_RESET;
        fields.rd = rd_s;
        if (legal_s) begin
            fields.op       = op_s;
            fields.operand1 = opnd1_s;
            fields.operand2 = opnd2_s;
            fields.rd_we    = (rd_s != 5'd0);
            fields.illegal  = 1'b0;
        end else begin
            fields.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: valid/ready intake from fetch, register-file read with
// writeback bypass, one-entry pipeline register toward EX, and issue counter.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_operator,
    output logic [31:0] out_operand1,
    output logic [31:0] out_operand2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal,
    output logic [31:0] issue_count
);

    logic        accept_s;
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    issue_t      dec_s;
    issue_t      entry_r;
    logic        out_valid_r;
    logic [31:0] count_r;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // The slot can take a new instruction when empty or being drained this cycle.
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Writeback bypass: x0 is never forwarded.
    assign src1_s = (wb_en && (wb_addr != 5'd0) && (wb_addr == rs1_addr)) ? wb_data : rs1_data;
    assign src2_s = (wb_en && (wb_addr != 5'd0) && (wb_addr == rs2_addr)) ? wb_data : rs2_data;

    alu_issue_decode u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .src1   (src1_s),
        .src2   (src2_s),
        .fields (dec_s)
    );

    // Pipeline register: flush wins over accept; a stalled entry holds every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            entry_r     <= ISSUE_RESET;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            entry_r     <= dec_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Count every entry handed to EX; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (out_valid_r && out_ready) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_operator = entry_r.op;
    assign out_operand1 = entry_r.operand1;
    assign out_operand2 = entry_r.operand2;
    assign out_rd       = entry_r.rd;
    assign out_rd_we    = entry_r.rd_we;
    assign out_illegal  = entry_r.illegal;
    assign issue_count  = count_r;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: table of instruction vectors with hand-derived expected
// fields, a scoreboard queue filled on accept and drained on handoff, and
// hand-written stall / flush / mid-stall reset sequences.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_operator;
    logic [31:0] out_operand1;
    logic [31:0] out_operand2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] issue_count;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operator(out_operator), .out_operand1(out_operand1),
        .out_operand2(out_operand2), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal), .issue_count(issue_count)
    );

    // Register file model
    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t        tbl [16];
    vec_t        sb [$];
    vec_t        idle;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_count = 32'd0;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic we_wb, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [3:0] op, input logic [31:0] op1, input logic [31:0] op2,
                                input logic [4:0] rd, input logic we, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.wb_en = we_wb; v.wb_addr = wa; v.wb_data = wd;
        v.op = op; v.op1 = op1; v.op2 = op2; v.rd = rd; v.we = we; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the scoreboard, then advance the model.
    task automatic step(input logic v, input vec_t t, input logic ordy, input logic fl);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_instr  = t.instr;
        in_pc     = t.pc;
        wb_en     = t.wb_en;
        wb_addr   = t.wb_addr;
        wb_data   = t.wb_data;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = (sb.size() == 0) || ordy;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("issue_count", issue_count, exp_count);
        if (sb.size() != 0) begin
            chk("operator", {28'd0, out_operator}, {28'd0, sb[0].op});
            chk("operand1", out_operand1, sb[0].op1);
            chk("operand2", out_operand2, sb[0].op2);
            chk("rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
            chk("rd_we", {31'd0, out_rd_we}, {31'd0, sb[0].we});
            chk("illegal", {31'd0, out_illegal}, {31'd0, sb[0].ill});
            if (ordy) begin
                void'(sb.pop_front());
                exp_count = exp_count + 32'd1;
            end
        end
        if (fl) begin
            sb.delete();
        end else if (v && exp_rdy) begin
            sb.push_back(t);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd10;
        regs[2] = 32'd3;
        regs[3] = 32'h0000_00F0;
        regs[4] = 32'h8000_0010;
        regs[5] = 32'd5;

        idle = mk(32'h0000_0000, 32'd0, 1'b0, 5'd0, 32'd0, ALU_OPERATOR_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

        //            instr         pc         wb   wa     wd             op                 op1            op2            rd     we    ill
        tbl[0]  = mk(32'h402081B3, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_SUB,  32'd10,        32'd3,         5'd3,  1'b1, 1'b0);
        tbl[1]  = mk(32'hFFD08293, 32'h0,     1'b1, 5'd1, 32'd7,         ALU_OPERATOR_ADD,  32'd7,         32'hFFFFFFFD,  5'd5,  1'b1, 1'b0);
        tbl[2]  = mk(32'h123453B7, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd0,         32'h12345000,  5'd7,  1'b1, 1'b0);
        tbl[3]  = mk(32'h12345397, 32'h100,   1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'h100,       32'h12345000,  5'd7,  1'b1, 1'b0);
        tbl[4]  = mk(32'h40325213, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_SRA,  32'h80000010,  32'd3,         5'd4,  1'b1, 1'b0);
        tbl[5]  = mk(32'hC0325213, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd0,         32'd0,         5'd4,  1'b0, 1'b1);
        tbl[6]  = mk(32'h003170B3, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd0,         32'd0,         5'd1,  1'b0, 1'b1);
        tbl[7]  = mk(32'h00208033, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd10,        32'd3,         5'd0,  1'b0, 1'b0);
        tbl[8]  = mk(32'h0020B333, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_SLTU, 32'd10,        32'd3,         5'd6,  1'b1, 1'b0);
        tbl[9]  = mk(32'h01F09413, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_SLL,  32'd10,        32'd31,        5'd8,  1'b1, 1'b0);
        tbl[10] = mk(32'h41F09413, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd0,         32'd0,         5'd8,  1'b0, 1'b1);
        tbl[11] = mk(32'h7FF16493, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_OR,   32'd3,         32'h7FF,       5'd9,  1'b1, 1'b0);
        tbl[12] = mk(32'h0000007F, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd0,         32'd0,         5'd0,  1'b0, 1'b1);
        tbl[13] = mk(32'h00500513, 32'h0,     1'b1, 5'd0, 32'h55,        ALU_OPERATOR_ADD,  32'd0,         32'd5,         5'd10, 1'b1, 1'b0);
        tbl[14] = mk(32'h402255B3, 32'h0,     1'b1, 5'd2, 32'h1F,        ALU_OPERATOR_SRA,  32'h80000010,  32'h1F,        5'd11, 1'b1, 1'b0);
        tbl[15] = mk(32'h0000F7B3, 32'h0,     1'b0, 5'd0, 32'd0,         ALU_OPERATOR_ADD,  32'd0,         32'd0,         5'd15, 1'b0, 1'b1);

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst operator", {28'd0, out_operator}, {28'd0, ALU_OPERATOR_ADD});
        chk("rst operand1", out_operand1, 32'd0);
        chk("rst operand2", out_operand2, 32'd0);
        chk("rst rd", {27'd0, out_rd}, 32'd0);
        chk("rst rd_we", {31'd0, out_rd_we}, 32'd0);
        chk("rst illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst issue_count", issue_count, 32'd0);
        rst = 1'b0;

        // Back-to-back table vectors
        for (int i = 0; i < 16; i++) step(1'b1, tbl[i], 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Stall: SUB held for 3 cycles while x1 writebacks must not refresh op1
        step(1'b1, tbl[0], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, tbl[1], 1'b0, 1'b0);
        step(1'b1, tbl[1], 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Flush: held entry dropped, same-cycle accept discarded
        step(1'b1, tbl[2], 1'b1, 1'b0);
        step(1'b1, tbl[6], 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);
        // Flush while the entry is handed off: counted, the accept discarded
        step(1'b1, tbl[3], 1'b1, 1'b0);
        step(1'b1, tbl[6], 1'b1, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b1, tbl[6], 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Reset in the middle of a stall drops the held entry and clears the count
        step(1'b1, tbl[4], 1'b1, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst issue_count", issue_count, 32'd0);
        chk("midrst operand1", out_operand1, 32'd0);
        sb.delete();
        exp_count = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, tbl[8], 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
